// File: rtl/pulse_width_meter_pkg.sv
// Shared types for the pulse width meter.
//   pw_state_t : measurement FSM state (IDLE, MEASURE)
//   pw_rec_t   : default record layout {width, level, timeout} at the
//                default counter width; the top builds the same layout
//                at its own CNT_W and hands it to the output slot.
package pulse_width_meter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } pw_state_t;

   localparam int unsigned PW_CNT_W_DEFAULT = 16;

   typedef struct packed {
      logic [PW_CNT_W_DEFAULT-1:0] width;
      logic                        level;
      logic                        timeout;
   } pw_rec_t;

endpackage

// File: rtl/pulse_width_meter_if.sv
// Measurement record channel (valid/ready).
//   meas_valid   : record available (master -> slave)
//   meas_ready   : slave accepts record (slave -> master)
//   meas_width   : segment length in cycles
//   meas_level   : level of the measured segment
//   meas_timeout : record closed by timeout rather than by an edge
interface pulse_width_meter_if #(
   parameter int unsigned CNT_W = 16
);
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_width;
   logic             meas_level;
   logic             meas_timeout;

   modport master (
      output meas_valid, meas_width, meas_level, meas_timeout,
      input  meas_ready
   );

   modport slave (
      input  meas_valid, meas_width, meas_level, meas_timeout,
      output meas_ready
   );
endinterface

// File: rtl/pulse_width_meter_pw_out_slot.sv
// One-entry valid/ready holding register for measurement records.
//   clk, reset   : clock, synchronous active-high reset
//   load         : a record is offered this cycle
//   rec_in       : the offered record
//   clr_overrun  : clears the sticky overrun flag
//   overrun      : sticky, set when an offered record had to be dropped
//   meas         : record channel (master side)
module pw_out_slot
   import pulse_width_meter_pkg::*;
#(
   parameter type rec_t = pw_rec_t
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  rec_t                       rec_in,
   input  logic                       clr_overrun,
   output logic                       overrun,
   pulse_width_meter_if.master        meas
);

   logic valid_q;
   rec_t rec_q;
   logic accept;
   logic drop;

   // Slot is free when empty or being drained this cycle.
   assign accept = !valid_q || meas.meas_ready;
   assign drop   = load && !accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
         overrun <= 1'b0;
      end else begin
         if (load && accept) begin
            rec_q   <= rec_in;
            valid_q <= 1'b1;
         end else if (meas.meas_ready) begin
            valid_q <= 1'b0;
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

   assign meas.meas_valid   = valid_q;
   assign meas.meas_width   = rec_q.width;
   assign meas.meas_level   = rec_q.level;
   assign meas.meas_timeout = rec_q.timeout;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high/low segment durations from edge pulses and emits one
// record per completed segment.
//   clk, reset   : clock, synchronous active-high reset
//   edge_in      : one-cycle pulse marking a transition
//   level_in     : new level after the transition (aligned with edge_in)
//   meas         : record channel (valid/ready, width/level/timeout)
//   overrun      : sticky record-dropped flag
//   clr_overrun  : clears overrun
module pulse_width_meter
   import pulse_width_meter_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                edge_in,
   input  logic                level_in,
   input  logic                clr_overrun,
   output logic                overrun,
   pulse_width_meter_if.master meas
);

   typedef struct packed {
      logic [CNT_W-1:0] width;
      logic             level;
      logic             timeout;
   } rec_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   pw_state_t        state;
   pw_state_t        state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic             gen;
   rec_t             rec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // cnt is bounded by TIMEOUT, so the increment never wraps.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         IDLE: begin
            if (edge_in) begin
               state_d = MEASURE;
               cnt_d   = CNT_W'(1);
            end
         end
         MEASURE: begin
            if (edge_in)
               cnt_d = CNT_W'(1);
            else if (cnt == TIMEOUT_C)
               state_d = IDLE;
            else
               cnt_d = cnt + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // An edge on the timeout cycle takes priority and closes normally.
   always_comb begin
      gen = 1'b0;
      rec = '0;
      if (state == MEASURE) begin
         if (edge_in) begin
            gen         = 1'b1;
            rec.width   = cnt;
            rec.level   = ~level_in;
            rec.timeout = 1'b0;
         end else if (cnt == TIMEOUT_C) begin
            gen         = 1'b1;
            rec.width   = TIMEOUT_C;
            rec.level   = level_in;
            rec.timeout = 1'b1;
         end
      end
   end

   pw_out_slot #(
      .rec_t (rec_t)
   ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (gen),
      .rec_in      (rec),
      .clr_overrun (clr_overrun),
      .overrun     (overrun),
      .meas        (meas)
   );

endmodule
